// File: rtl/bitperm_pkg.sv
// Shared types and parameter checks for the bit-permutation pipeline.
package bitperm_pkg;

  typedef enum logic [1:0] {
    PASS     = 2'd0,
    REV_WORD = 2'd1,
    REV_LANE = 2'd2,
    ROT      = 2'd3
  } bitperm_mode_t;

  function automatic bit bitperm_params_ok(input int unsigned width,
                                           input int unsigned lanes);
    return (width >= 2) && (lanes >= 1) && ((width % lanes) == 0);
  endfunction

endpackage

// File: rtl/bitperm_net.sv
// Purely combinational permutation network: pass, word reverse, lane reverse, rotate.
module bitperm_net
  import bitperm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2,
  localparam int unsigned RW   = $clog2(WIDTH),
  localparam int unsigned LW   = WIDTH / LANES
) (
  input  logic [WIDTH-1:0] a_i,
  input  bitperm_mode_t    mode_i,
  input  logic [RW-1:0]    rot_i,
  output logic [WIDTH-1:0] a_o
);

  logic [WIDTH-1:0]   rev_word;
  logic [WIDTH-1:0]   rev_lane;
  logic [WIDTH-1:0]   rotated;
  logic [2*WIDTH-1:0] dbl;
  int unsigned        r;

  always_comb begin
    rev_word = '0;
    rev_lane = '0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      rev_word[k] = a_i[WIDTH-1-k];
    end
    for (int unsigned j = 0; j < LANES; j++) begin
      for (int unsigned m = 0; m < LW; m++) begin
        rev_lane[j*LW+m] = a_i[j*LW+LW-1-m];
      end
    end
    // Left rotate via doubled word; r is reduced so non-power-of-two widths wrap correctly.
    r       = 32'(rot_i) % WIDTH;
    dbl     = {a_i, a_i} << r;
    rotated = dbl[2*WIDTH-1 -: WIDTH];
  end

  always_comb begin
    a_o = a_i;
    unique case (mode_i)
      PASS:     a_o = a_i;
      REV_WORD: a_o = rev_word;
      REV_LANE: a_o = rev_lane;
      ROT:      a_o = rotated;
      default:  a_o = a_i;
    endcase
  end

endmodule

// File: rtl/bitperm_pipe.sv
// Two-stage valid/ready bit-permutation pipeline: capture register, then permuted output register.
module bitperm_pipe
  import bitperm_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned LANES = 2,
  localparam int unsigned RW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [1:0]       i_mode,
  input  logic [RW-1:0]    i_rot,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_a
);

  if (!bitperm_params_ok(WIDTH, LANES)) begin : g_param_err
    $error("bitperm_pipe: WIDTH must be >= 2 and a multiple of LANES");
  end

  logic [WIDTH-1:0] a_q, a_d;
  bitperm_mode_t    mode_q, mode_d;
  logic [RW-1:0]    rot_q, rot_d;
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] perm;
  logic             accept;
  logic             load2;

  bitperm_net #(
    .WIDTH (WIDTH),
    .LANES (LANES)
  ) u_net (
    .a_i    (a_q),
    .mode_i (mode_q),
    .rot_i  (rot_q),
    .a_o    (perm)
  );

  assign o_ready = !i_rst && (!s1_valid_q || !out_valid_q || i_ready);
  assign accept  = i_valid && o_ready;
  assign load2   = s1_valid_q && (!out_valid_q || i_ready);

  always_comb begin
    a_d         = a_q;
    mode_d      = mode_q;
    rot_d       = rot_q;
    s1_valid_d  = s1_valid_q;
    out_d       = out_q;
    out_valid_d = out_valid_q;

    if (load2) begin
      out_d       = perm;
      out_valid_d = 1'b1;
    end else if (out_valid_q && i_ready) begin
      out_valid_d = 1'b0;
    end

    // Accept and hand-off may share an edge: the new beat replaces the one moving to stage 2.
    if (accept) begin
      a_d        = i_a;
      mode_d     = bitperm_mode_t'(i_mode);
      rot_d      = i_rot;
      s1_valid_d = 1'b1;
    end else if (load2) begin
      s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      a_q         <= '0;
      mode_q      <= PASS;
      rot_q       <= '0;
      s1_valid_q  <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      a_q         <= a_d;
      mode_q      <= mode_d;
      rot_q       <= rot_d;
      s1_valid_q  <= s1_valid_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign o_valid = out_valid_q;
  assign o_a     = out_q;

endmodule

// File: tb/tb_bitperm_pipe.sv
// Directed self-checking bench for bitperm_pipe (8/2 main instance plus 4/1 and 6/2 variants).
module tb_bitperm_pipe;
  import bitperm_pkg::*;

  logic clk;
  logic rst;

  logic       v8, rdy8, ov8, ir8;
  logic [7:0] a8, oa8;
  logic [1:0] m8;
  logic [2:0] r8;

  logic       v4, rdy4, ov4, ir4;
  logic [3:0] a4, oa4;
  logic [1:0] m4;
  logic [1:0] r4;

  logic       v6, rdy6, ov6, ir6;
  logic [5:0] a6, oa6;
  logic [1:0] m6;
  logic [2:0] r6;

  int passed = 0;
  int total  = 0;

  bitperm_pipe #(.WIDTH(8), .LANES(2)) dut8 (
    .i_clk(clk), .i_rst(rst), .i_valid(v8), .o_ready(rdy8), .i_a(a8),
    .i_mode(m8), .i_rot(r8), .o_valid(ov8), .i_ready(ir8), .o_a(oa8)
  );

  bitperm_pipe #(.WIDTH(4), .LANES(1)) dut4 (
    .i_clk(clk), .i_rst(rst), .i_valid(v4), .o_ready(rdy4), .i_a(a4),
    .i_mode(m4), .i_rot(r4), .o_valid(ov4), .i_ready(ir4), .o_a(oa4)
  );

  bitperm_pipe #(.WIDTH(6), .LANES(2)) dut6 (
    .i_clk(clk), .i_rst(rst), .i_valid(v6), .o_ready(rdy6), .i_a(a6),
    .i_mode(m6), .i_rot(r6), .o_valid(ov6), .i_ready(ir6), .o_a(oa6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic test_reset();
    rst = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; m8 = REV_WORD; r8 = '0; ir8 = 1'b1;
    v4 = 1'b1; a4 = 4'hF;  m4 = PASS;     r4 = '0; ir4 = 1'b1;
    v6 = 1'b1; a6 = 6'h3F; m6 = PASS;     r6 = '0; ir6 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #2;
      total++;
      if ({rdy8, rdy4, rdy6} !== 3'b000)
        $display("FAIL reset_ready cyc%0d: got %b want 000", c, {rdy8, rdy4, rdy6});
      else passed++;
      @(posedge clk); #1;
    end
    rst = 1'b0;
    v8 = 1'b0; v4 = 1'b0; v6 = 1'b0;
    #1;
    total++;
    if (ov8 !== 1'b0) $display("FAIL reset_ovalid: got %b want 0", ov8); else passed++;
    total++;
    if (oa8 !== 8'h00) $display("FAIL reset_oa: got %h want 00", oa8); else passed++;
    total++;
    if ({rdy8, rdy4, rdy6} !== 3'b111)
      $display("FAIL reset_release_ready: got %b want 111", {rdy8, rdy4, rdy6});
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_modes();
    logic [1:0] md  [5];
    logic [2:0] rt  [5];
    logic [7:0] din [5];
    logic [7:0] exp [5];
    md[0] = REV_WORD; rt[0] = 3'd0; din[0] = 8'h01; exp[0] = 8'h80;
    md[1] = REV_LANE; rt[1] = 3'd5; din[1] = 8'hC1; exp[1] = 8'h38;
    md[2] = PASS;     rt[2] = 3'd2; din[2] = 8'h5A; exp[2] = 8'h5A;
    md[3] = ROT;      rt[3] = 3'd3; din[3] = 8'h81; exp[3] = 8'h0C;
    md[4] = ROT;      rt[4] = 3'd0; din[4] = 8'h81; exp[4] = 8'h81;
    ir8 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      v8 = 1'b1; a8 = din[i]; m8 = md[i]; r8 = rt[i];
      #1;
      total++;
      if (rdy8 !== 1'b1) $display("FAIL mode%0d_ready: got %b want 1", i, rdy8); else passed++;
      @(posedge clk); #1;
      v8 = 1'b0; a8 = 8'h00; m8 = PASS;
      total++;
      if (ov8 !== 1'b0) $display("FAIL mode%0d_early_valid: got %b want 0", i, ov8); else passed++;
      @(posedge clk); #1;
      total++;
      if (ov8 !== 1'b1 || oa8 !== exp[i])
        $display("FAIL mode%0d_out: got v=%b a=%h want v=1 a=%h", i, ov8, oa8, exp[i]);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_small_widths();
    v4 = 1'b1; a4 = 4'b0011;   m4 = REV_WORD; r4 = 2'd0; ir4 = 1'b1;
    v6 = 1'b1; a6 = 6'b100001; m6 = ROT;      r6 = 3'd7; ir6 = 1'b1;
    @(posedge clk); #1;
    v4 = 1'b0; v6 = 1'b0;
    @(posedge clk); #1;
    total++;
    if (ov4 !== 1'b1 || oa4 !== 4'b1100)
      $display("FAIL w4_rev_word: got v=%b a=%b want v=1 a=1100", ov4, oa4);
    else passed++;
    total++;
    if (ov6 !== 1'b1 || oa6 !== 6'b000011)
      $display("FAIL w6_rot7: got v=%b a=%b want v=1 a=000011", ov6, oa6);
    else passed++;
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back();
    logic [1:0] md  [3];
    logic [7:0] din [3];
    logic [7:0] exp [3];
    md[0] = PASS;     din[0] = 8'hA5; exp[0] = 8'hA5;
    md[1] = REV_WORD; din[1] = 8'h0F; exp[1] = 8'hF0;
    md[2] = REV_LANE; din[2] = 8'h12; exp[2] = 8'h84;
    ir8 = 1'b1; r8 = '0;
    for (int c = 0; c < 5; c++) begin
      if (c < 3) begin
        v8 = 1'b1; a8 = din[c]; m8 = md[c];
        #1;
        total++;
        if (rdy8 !== 1'b1) $display("FAIL b2b_ready%0d: got %b want 1", c, rdy8); else passed++;
      end else begin
        v8 = 1'b0;
      end
      @(posedge clk); #1;
      if (c >= 1 && c <= 3) begin
        total++;
        if (ov8 !== 1'b1 || oa8 !== exp[c-1])
          $display("FAIL b2b_out%0d: got v=%b a=%h want v=1 a=%h", c - 1, ov8, oa8, exp[c-1]);
        else passed++;
      end
    end
  endtask

  task automatic test_backpressure();
    logic [1:0] md  [4];
    logic [2:0] rt  [4];
    logic [7:0] din [4];
    logic [7:0] exp [4];
    logic       rdy_exp [10];
    int idx  = 0;
    int pops = 0;
    md[0] = PASS;     rt[0] = 3'd0; din[0] = 8'h5A; exp[0] = 8'h5A;
    md[1] = REV_WORD; rt[1] = 3'd0; din[1] = 8'h01; exp[1] = 8'h80;
    md[2] = REV_LANE; rt[2] = 3'd0; din[2] = 8'hC1; exp[2] = 8'h38;
    md[3] = ROT;      rt[3] = 3'd3; din[3] = 8'h81; exp[3] = 8'h0C;
    rdy_exp = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int c = 0; c < 12; c++) begin
      ir8 = !(c >= 2 && c <= 5);
      if (idx < 4) begin
        v8 = 1'b1; a8 = din[idx]; m8 = md[idx]; r8 = rt[idx];
      end else begin
        v8 = 1'b0;
      end
      #1;
      if (c < 10) begin
        total++;
        if (rdy8 !== rdy_exp[c])
          $display("FAIL bp_ready cyc%0d: got %b want %b", c, rdy8, rdy_exp[c]);
        else passed++;
      end
      if (c >= 2 && c <= 5) begin
        total++;
        if (ov8 !== 1'b1 || oa8 !== 8'h5A)
          $display("FAIL bp_stall_hold cyc%0d: got v=%b a=%h want v=1 a=5a", c, ov8, oa8);
        else passed++;
      end
      if (ov8 === 1'b1 && ir8 === 1'b1) begin
        total++;
        if (pops >= 4)
          $display("FAIL bp_extra_beat: got a=%h want no beat", oa8);
        else if (oa8 !== exp[pops])
          $display("FAIL bp_beat%0d: got %h want %h", pops, oa8, exp[pops]);
        else passed++;
        pops++;
      end
      if (v8 === 1'b1 && rdy8 === 1'b1) idx++;
      @(posedge clk); #1;
    end
    v8 = 1'b0;
    total++;
    if (pops !== 4 || idx !== 4)
      $display("FAIL bp_count: got pops=%0d accepts=%0d want 4 4", pops, idx);
    else passed++;
  endtask

  task automatic test_mid_reset();
    ir8 = 1'b0; r8 = '0;
    v8 = 1'b1; a8 = 8'h11; m8 = PASS;
    @(posedge clk); #1;
    a8 = 8'h22; m8 = REV_WORD;
    @(posedge clk); #1;
    v8 = 1'b0;
    rst = 1'b1;
    #1;
    total++;
    if (rdy8 !== 1'b0) $display("FAIL midrst_ready: got %b want 0", rdy8); else passed++;
    @(posedge clk); #1;
    rst = 1'b0;
    ir8 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (ov8 !== 1'b0) $display("FAIL midrst_no_emit%0d: got %b want 0", c, ov8); else passed++;
      @(posedge clk); #1;
    end
    v8 = 1'b1; a8 = 8'h3C; m8 = PASS;
    #1;
    total++;
    if (rdy8 !== 1'b1) $display("FAIL midrst_ready_after: got %b want 1", rdy8); else passed++;
    @(posedge clk); #1;
    v8 = 1'b0;
    total++;
    if (ov8 !== 1'b0) $display("FAIL midrst_lat_early: got %b want 0", ov8); else passed++;
    @(posedge clk); #1;
    total++;
    if (ov8 !== 1'b1 || oa8 !== 8'h3C)
      $display("FAIL midrst_lat_out: got v=%b a=%h want v=1 a=3c", ov8, oa8);
    else passed++;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_modes();
    test_small_widths();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
